// File: rtl/uart_pkg.sv
// uart_pkg: register map, field positions and shared enums for the UART APB register block
package uart_pkg;
  localparam logic [7:0] OFF_BAUD    = 8'h00;
  localparam logic [7:0] OFF_DATA    = 8'h04;
  localparam logic [7:0] OFF_STOP    = 8'h08;
  localparam logic [7:0] OFF_CHECK   = 8'h0C;
  localparam logic [7:0] OFF_ENABLE  = 8'h10;
  localparam logic [7:0] OFF_DATA_WT = 8'h14;
  localparam logic [7:0] OFF_DATA_RD = 8'h18;
  localparam logic [7:0] OFF_STATUS  = 8'h1C;
  localparam int EN_RX   = 0;
  localparam int EN_TX   = 1;
  localparam int EN_RXIE = 2;
  localparam int EN_TXIE = 3;
  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_OVERRUN  = 3;
  typedef enum logic [1:0] {CHK_NONE, CHK_ODD, CHK_EVEN, CHK_NONE_ALT} parity_e;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} apb_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular TX byte buffer with extra-MSB pointers for full/empty
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/uart_apb_regs.sv
// uart_apb_regs: APB3 slave for UART configuration, TX FIFO push, RX capture and interrupt
module uart_apb_regs
  import uart_pkg::*;
#(
  parameter int TX_DEPTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [15:0]           cfg_baud,
  output logic [1:0]            cfg_data,
  output logic                  cfg_stop,
  output logic [1:0]            cfg_check,
  output logic                  tx_en,
  output logic                  rx_en,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  irq
);
  apb_state_e state, state_n;
  parity_e check;
  logic [3:0] enable, status;
  logic [7:0] off, rx_hold;
  logic [31:0] rd_mux;
  logic rx_full, rx_overrun, tx_full, tx_empty;
  logic bad, done, wr, push, rd_clr, rx_take, rx_drop;
  logic unused_bits;
  assign unused_bits = ^{paddr[ADDR_WIDTH-1:8], pwdata[31:16]};
  assign off       = paddr[7:0];
  assign pready    = state == S_RESP;
  assign cfg_check = check;
  assign tx_en     = enable[EN_TX];
  assign rx_en     = enable[EN_RX];
  assign tx_valid  = !tx_empty;
  assign status    = {rx_overrun, rx_full, tx_full, tx_empty};
  // Error is decided when entering the response cycle, so a full FIFO is judged before any pop there
  assign bad     = (|off[1:0]) || (|off[7:5]) || (pwrite && off == OFF_DATA_WT && tx_full);
  assign done    = pready && psel && penable && !pslverr;
  assign wr      = done && pwrite;
  assign push    = wr && off == OFF_DATA_WT;
  assign rd_clr  = done && !pwrite && off == OFF_DATA_RD;
  assign rx_take = rx_valid && rx_en && (!rx_full || rd_clr);
  assign rx_drop = rx_valid && rx_en && rx_full && !rd_clr;
  always_comb begin
    state_n = S_IDLE;
    if (psel)
      state_n = state == S_IDLE   ? (penable ? S_IDLE : S_SETUP) :
                state == S_SETUP  ? (penable ? S_ACCESS : S_SETUP) :
                state == S_ACCESS ? S_RESP : S_IDLE;
  end
  always_comb begin
    rd_mux = '0;
    rd_mux = off == OFF_BAUD    ? {16'b0, cfg_baud} :
             off == OFF_DATA    ? {30'b0, cfg_data} :
             off == OFF_STOP    ? {31'b0, cfg_stop} :
             off == OFF_CHECK   ? {30'b0, check} :
             off == OFF_ENABLE  ? {28'b0, enable} :
             off == OFF_DATA_RD ? {24'b0, rx_full ? rx_hold : 8'h00} :
             off == OFF_STATUS  ? {28'b0, status} : 32'b0;
  end
  uart_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_fifo (
    .clk(pclk),
    .rst(prst),
    .push(push),
    .din(pwdata[7:0]),
    .pop(tx_valid && tx_ready),
    .dout(tx_data),
    .full(tx_full),
    .empty(tx_empty)
  );
  always_ff @(posedge pclk)
    if (prst) begin
      state      <= S_IDLE;
      prdata     <= '0;
      pslverr    <= 1'b0;
      cfg_baud   <= '0;
      cfg_data   <= '0;
      cfg_stop   <= 1'b0;
      check      <= CHK_NONE;
      enable     <= '0;
      rx_hold    <= '0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state   <= state_n;
      pslverr <= state == S_ACCESS && psel && bad;
      prdata  <= (state == S_ACCESS && psel && !pwrite && !bad) ? rd_mux : '0;
      if (wr && off == OFF_BAUD)   cfg_baud <= pwdata[15:0];
      if (wr && off == OFF_DATA)   cfg_data <= pwdata[1:0];
      if (wr && off == OFF_STOP)   cfg_stop <= pwdata[0];
      if (wr && off == OFF_CHECK)  check    <= parity_e'(pwdata[1:0]);
      if (wr && off == OFF_ENABLE) enable   <= pwdata[3:0];
      if (wr && off == OFF_STATUS && pwdata[STAT_OVERRUN]) rx_overrun <= 1'b0;
      if (rx_drop) rx_overrun <= 1'b1;
      if (rx_take) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (rd_clr) rx_full <= 1'b0;
      irq <= (enable[EN_TXIE] && tx_empty) || (enable[EN_RXIE] && rx_full);
    end
endmodule

// File: tb/tb_uart_apb_regs.sv
// tb_uart_apb_regs: directed vector bench for the UART APB register block
module tb_uart_apb_regs;
  logic pclk, prst, psel, penable, pwrite, tx_ready, rx_valid;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr, cfg_stop, tx_en, rx_en, tx_valid, irq;
  logic [15:0] cfg_baud;
  logic [1:0] cfg_data, cfg_check;
  logic [7:0] tx_data, rx_data;
  int passed = 0, total = 0;

  uart_apb_regs #(.TX_DEPTH(4), .ADDR_WIDTH(32)) dut (
    .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .cfg_baud(cfg_baud), .cfg_data(cfg_data), .cfg_stop(cfg_stop), .cfg_check(cfg_check),
    .tx_en(tx_en), .rx_en(rx_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
  );

  initial pclk = 0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;
  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic prx, input logic [7:0] rb,
                     output logic [31:0] rd, output logic er);
    int n = 0;
    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = w; paddr = {24'b0, a}; pwdata = d;
    @(posedge pclk); #1;
    penable = 1;
    while (!pready && n < 8) begin
      @(posedge pclk); #1;
      n++;
    end
    chk("pready_latency", n, 2);
    rd = prdata;
    er = pslverr;
    if (prx) begin
      rx_valid = 1;
      rx_data = rb;
    end
    @(posedge pclk); #1;
    psel = 0; penable = 0; rx_valid = 0;
  endtask

  task automatic xfer(input string nm, input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    apb(w, a, d, 1'b0, 8'h00, rd, er);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {31'b0, er}, {31'b0, exp_er});
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge pclk); #1;
    rx_valid = 1; rx_data = b;
    @(posedge pclk); #1;
    rx_valid = 0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [7:0] got[$];
    logic [7:0] exp_bytes[4];
    int n;
    exp_bytes = '{8'h33, 8'h21, 8'h55, 8'hAA};
    vt[0]  = '{1'b0, 8'h00, 32'h0,     32'd5208, 1'b0};
    vt[1]  = '{1'b1, 8'h04, 32'h1,     32'h0,    1'b0};
    vt[2]  = '{1'b1, 8'h08, 32'h0,     32'h0,    1'b0};
    vt[3]  = '{1'b1, 8'h0C, 32'h2,     32'h0,    1'b0};
    vt[4]  = '{1'b1, 8'h10, 32'h2,     32'h0,    1'b0};
    vt[5]  = '{1'b0, 8'h1C, 32'h0,     32'h1,    1'b0};
    vt[6]  = '{1'b0, 8'h04, 32'h0,     32'h1,    1'b0};
    vt[7]  = '{1'b0, 8'h0C, 32'h0,     32'h2,    1'b0};
    vt[8]  = '{1'b1, 8'h24, 32'hFFFF,  32'h0,    1'b1};
    vt[9]  = '{1'b1, 8'h02, 32'h1234,  32'h0,    1'b1};
    vt[10] = '{1'b0, 8'h00, 32'h0,     32'd5208, 1'b0};
    vt[11] = '{1'b0, 8'h24, 32'h0,     32'h0,    1'b1};
    vt[12] = '{1'b0, 8'h14, 32'h0,     32'h0,    1'b0};
    vt[13] = '{1'b1, 8'h08, 32'h3,     32'h0,    1'b0};
    vt[14] = '{1'b0, 8'h08, 32'h0,     32'h1,    1'b0};
    vt[15] = '{1'b0, 8'h10, 32'h0,     32'h2,    1'b0};

    prst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    repeat (3) @(posedge pclk);
    #1 prst = 0;
    chk("rst_pready", {31'b0, pready}, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_baud", {16'b0, cfg_baud}, 0);

    xfer("wr_baud", 1'b1, 8'h00, 32'd5208, 32'h0, 1'b0);
    chk("cfg_baud", {16'b0, cfg_baud}, 32'd5208);

    foreach (vt[i]) begin
      xfer($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].rd, vt[i].er);
    end
    chk("cfg_data", {30'b0, cfg_data}, 1);
    chk("cfg_check", {30'b0, cfg_check}, 2);
    chk("cfg_stop", {31'b0, cfg_stop}, 1);
    chk("tx_en", {31'b0, tx_en}, 1);
    chk("rx_en", {31'b0, rx_en}, 0);
    chk("cfg_baud_kept", {16'b0, cfg_baud}, 32'd5208);

    foreach (exp_bytes[i]) xfer("push", 1'b1, 8'h14, {24'b0, exp_bytes[i]}, 32'h0, 1'b0);
    chk("fifo_head", {24'b0, tx_data}, 32'h33);
    xfer("status_full", 1'b0, 8'h1C, 32'h0, 32'h2, 1'b0);
    xfer("push_full", 1'b1, 8'h14, 32'h77, 32'h0, 1'b1);
    tx_ready = 1;
    n = 0;
    while (n < 12) begin
      if (tx_valid) got.push_back(tx_data);
      @(posedge pclk); #1;
      n++;
    end
    tx_ready = 0;
    chk("drain_count", got.size(), 4);
    foreach (got[i]) if (i < 4) chk($sformatf("drain%0d", i), {24'b0, got[i]}, {24'b0, exp_bytes[i]});
    chk("drain_empty", {31'b0, tx_valid}, 0);

    pulse_rx(8'h11);
    xfer("rx_disabled", 1'b0, 8'h1C, 32'h0, 32'h1, 1'b0);
    xfer("en_rx", 1'b1, 8'h10, 32'h3, 32'h0, 1'b0);
    pulse_rx(8'h66);
    pulse_rx(8'h43);
    xfer("status_ovr", 1'b0, 8'h1C, 32'h0, 32'hD, 1'b0);
    xfer("rd_66", 1'b0, 8'h18, 32'h0, 32'h66, 1'b0);
    xfer("status_after_rd", 1'b0, 8'h1C, 32'h0, 32'h9, 1'b0);
    xfer("clr_ovr", 1'b1, 8'h1C, 32'h8, 32'h0, 1'b0);
    xfer("status_clr", 1'b0, 8'h1C, 32'h0, 32'h1, 1'b0);
    xfer("rd_empty", 1'b0, 8'h18, 32'h0, 32'h0, 1'b0);

    pulse_rx(8'h5A);
    apb(1'b0, 8'h18, 32'h0, 1'b1, 8'hB7, rd, er);
    chk("coinc_rd_old", rd, 32'h5A);
    xfer("coinc_status", 1'b0, 8'h1C, 32'h0, 32'h5, 1'b0);
    xfer("coinc_rd_new", 1'b0, 8'h18, 32'h0, 32'hB7, 1'b0);

    chk("irq_off", {31'b0, irq}, 0);
    xfer("en_irq", 1'b1, 8'h10, 32'hC, 32'h0, 1'b0);
    @(posedge pclk); #1;
    chk("irq_on", {31'b0, irq}, 1);

    @(posedge pclk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'h99;
    @(posedge pclk); #1;
    penable = 1;
    @(posedge pclk); #1;
    prst = 1;
    @(posedge pclk); #1;
    prst = 0; psel = 0; penable = 0;
    chk("rr_pready", {31'b0, pready}, 0);
    chk("rr_pslverr", {31'b0, pslverr}, 0);
    chk("rr_prdata", prdata, 0);
    chk("rr_tx_valid", {31'b0, tx_valid}, 0);
    chk("rr_irq", {31'b0, irq}, 0);
    chk("rr_cfg", {cfg_baud, cfg_data, cfg_stop, cfg_check, tx_en, rx_en, tx_data}, 0);
    repeat (3) @(posedge pclk);
    #1 chk("rr_no_push", {31'b0, tx_valid}, 0);
    xfer("rr_baud", 1'b0, 8'h00, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_apb_regs.md
# uart_apb_regs

APB3 slave register block of the UART, sitting directly downstream of the APB3 master on the peripheral bus. It decodes APB3 transfers into the UART configuration registers, pushes transmit bytes into a small TX FIFO drained by the UART transmit core, and captures received bytes for read-back. It also produces status and a level interrupt for the CPU.

## Interface
- `TX_DEPTH`, 4: TX FIFO depth; a power of two, at least 2.
- `ADDR_WIDTH`, 32: APB address width.
- `pclk` in 1: the single clock. All logic is on the rising edge.
- `prst` in 1: reset, synchronous and active-high.
- `psel`, `penable`, `pwrite` in 1 each: APB3 control.
- `paddr` in ADDR_WIDTH: byte address. Only `paddr[7:0]` is decoded.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: transfer complete.
- `pslverr` out 1: transfer error. Valid only while `pready` is high.
- `cfg_baud` out 16: baud divisor.
- `cfg_data` out 2: data bits. 00=5, 01=6, 10=7, 11=8.
- `cfg_stop` out 1: stop bits. 0=1 stop bit, 1=2 stop bits.
- `cfg_check` out 2: parity. 00=none, 01=odd, 10=even, 11=none.
- `tx_en` out 1: transmitter enable.
- `rx_en` out 1: receiver enable.
- `tx_data` out 8: TX FIFO head byte.
- `tx_valid` out 1: TX FIFO not empty.
- `tx_ready` in 1: core accepts the head byte.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse, received byte present.
- `irq` out 1: level interrupt.

## Operation
Register map (byte offsets; reset value 0 unless stated):
- 0x00 BAUD: RW, bits [15:0].
- 0x04 DATA: RW, bits [1:0].
- 0x08 STOP: RW, bit [0].
- 0x0C CHECK: RW, bits [1:0].
- 0x10 ENABLE: RW.
  - bit1 = tx_en, bit0 = rx_en.
  - bit3 = TX-empty interrupt enable, bit2 = RX interrupt enable.
- 0x14 DATA_WT: write pushes `pwdata[7:0]` into the TX FIFO. Reads return 0.
- 0x18 DATA_RD: read returns `{24'b0, rx_hold}` and clears `rx_full`. Reading while empty returns 0, with no error and no side effect.
- 0x1C STATUS:
  - bit0 tx_empty, bit1 tx_full, bit2 rx_full: read-only.
  - bit3 rx_overrun: sticky; writing 1 clears it.

Unused bits read as 0 and ignore writes.

Error cases (`pslverr=1`, no state change):
- Unmapped offsets, and offsets not aligned to 4 bytes.
- Write to DATA_WT while the TX FIFO is full; the byte is dropped.

TX FIFO:
- Circular buffer with `$clog2(TX_DEPTH)+1`-bit read/write pointers; the extra MSB gives full/empty disambiguation and wrap-around.
- Pop when `tx_valid && tx_ready`.
- A simultaneous push and pop on a full FIFO is still rejected: full is evaluated before the pop.
- A simultaneous push and pop on a non-empty, non-full FIFO leaves the count unchanged.

RX capture:
- `rx_valid` while `rx_full=0`: latch `rx_data` and set `rx_full`.
- `rx_valid` while `rx_full=1`: drop the new byte and set `rx_overrun`.
- `rx_valid` coinciding with a DATA_RD completion: the read returns the old byte, and the new byte is latched (`rx_full` stays 1).
- `rx_valid` is ignored while `rx_en=0`.

`irq = (ENABLE[3] & tx_empty) | (ENABLE[2] & rx_full)`, registered.

## Timing
APB state machine states:
- IDLE → SETUP when `psel & ~penable`.
- SETUP → ACCESS when `penable`.
- ACCESS: one wait state, then `pready=1` for exactly one cycle (two cycles after `penable` first rises), then return to IDLE.
- `psel` dropping mid-transfer aborts the transfer and returns to IDLE with no side effect.

Data timing:
- `prdata` and `pslverr` are registered and valid in the `pready` cycle. `prdata` is 0 otherwise.
- Register writes take effect on the edge ending the `pready` cycle, so `cfg_*` changes one cycle later.
- A FIFO push is visible on `tx_valid` one cycle after the `pready` cycle.
- Pop latency is zero: `tx_data` is the combinational FIFO head.

Reset (`prst=1` at an edge):
- All registers and FIFO pointers cleared; FSM goes to IDLE.
- `pready=0`, `pslverr=0`, `prdata=0`, `tx_valid=0`, `irq=0`.
- A transfer in flight during reset is discarded.

## Structure
- Package `uart_pkg`:
  - Register offset localparams: BAUD, DATA, STOP, CHECK, ENABLE, DATA_WT, DATA_RD, STATUS.
  - Parity enum.
  - APB FSM state enum.
  - Field bit positions for ENABLE and STATUS.
- Sub-module `uart_tx_fifo`, parameterised by DEPTH and WIDTH, with push/pop/full/empty. Instantiated once.

## Test plan
- Reset, then write BAUD = 5208 → `cfg_baud = 16'd5208` one cycle after `pready`, and `pready` comes exactly 2 cycles after `penable` rises. Reading BAUD back returns 5208.
- Write DATA=01, STOP=0, CHECK=10, ENABLE=0x2 → `cfg_data=01`, `cfg_check=10`, `tx_en=1`. Reading STATUS returns 0x1.
- With `tx_ready=0`, push 0x33, 0x21, 0x55, 0xAA → `tx_full=1`. A fifth push returns `pslverr=1`. With `tx_ready=1`, the core receives 0x33, 0x21, 0x55, 0xAA in order, then `tx_valid=0`.
- With `rx_en=1`: pulse `rx_valid` with 0x66, then with 0x43 before any read → DATA_RD returns 0x66, STATUS bit3=1. Write 0x8 to STATUS → bit3 clears.
- Access offset 0x24, then 0x02 → `pslverr=1` and no register changes. ENABLE=0xC with the FIFO empty → `irq=1`.
- Assert `prst` during the ACCESS phase of a DATA_WT write → no push, all outputs 0 the next cycle.
